pipe_traffic_ctrl: RTL and testbench

Parametrised successor to the fixed 5-stage pipeline traffic controller. It supports N stages and a vector of flush points, and it tracks stage occupancy itself in valid registers, so stages no longer report their own valid bits. It adds a drain/halt FSM, used for fence, CSR and debug quiesce, and a saturating stall-cycle counter per stage. It sits beside the pipeline registers in the core top level and drives each register's write-enable and bubble-insert controls.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/sat_counter.sv | 21 ++
 rtl/pipe_traffic_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_traffic_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types, stage indices and flush priority helper for the pipeline traffic controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    // Stage indices for the default 5-stage configuration
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Widest supported pipeline; flush vectors are zero-extended to this width
    localparam int MAX_STAGES = 16;

    // Returns the highest set flush point at or above stage 2, or 0 when there is none.
    // The highest index is the oldest instruction, so its flush wins.
    function automatic int oldest_flush(input logic [MAX_STAGES-1:0] fv);
        int k;
        k = 0;
        for (int i = 2; i < MAX_STAGES; i++) begin
            if (fv[i]) begin
                k = i;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear beats increment; the count sticks at all ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_traffic_ctrl.sv
// rtl/pipe_traffic_ctrl.sv - N-stage pipeline advance, bubble, flush, drain/halt and stall accounting
module pipe_traffic_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32,
    parameter int SW         = $clog2(NUM_STAGES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_STAGES-1:0]       stall,
    input  logic                        fetch_valid,
    input  logic [NUM_STAGES-1:0]       flush_vec,
    input  logic                        drain_req,
    input  logic                        resume_req,
    input  logic                        cnt_clear,
    output logic [NUM_STAGES-1:0]       wr_en,
    output logic [NUM_STAGES-1:0]       gen_bubble,
    output logic [NUM_STAGES-1:0]       valid,
    output logic                        drained,
    output logic [NUM_STAGES*CNT_W-1:0] stall_cnt
);

    state_e                     state;
    logic [NUM_STAGES-1:1]      valid_r;
    logic [NUM_STAGES-1:0]      base_wr;
    logic [MAX_STAGES-1:0]      flush_ext;
    logic [SW-1:0]              flush_k;
    logic                       flush_any;

    assign valid     = {valid_r, fetch_valid};
    assign drained   = (state == HALTED);
    assign flush_ext = MAX_STAGES'(flush_vec);
    assign flush_k   = SW'(oldest_flush(flush_ext));
    assign flush_any = (flush_k != '0);

    // Advance chain from the oldest stage back to IF, then bubble and flush overrides
    always_comb begin
        base_wr    = '0;
        wr_en      = '0;
        gen_bubble = '0;

        base_wr[NUM_STAGES-1] = !valid[NUM_STAGES-1] || !stall[NUM_STAGES-1];
        for (int s = NUM_STAGES - 2; s >= 1; s--) begin
            base_wr[s] = !valid[s] || (!stall[s] && base_wr[s+1]);
        end
        base_wr[0] = !stall[0] && base_wr[1];

        wr_en      = base_wr;
        wr_en[0]   = (state == RUN) ? base_wr[0] : 1'b0;

        gen_bubble[1] = stall[0] || !fetch_valid || (state != RUN);
        for (int s = 2; s < NUM_STAGES; s++) begin
            gen_bubble[s] = stall[s-1];
        end

        // The flushing stage keeps its own enable so it may stall and re-execute;
        // everything younger is overwritten with bubbles and IF latches the redirect.
        if (flush_any) begin
            for (int s = 1; s < NUM_STAGES; s++) begin
                if (s <= int'(flush_k)) begin
                    gen_bubble[s] = 1'b1;
                end
                if (s < int'(flush_k)) begin
                    wr_en[s] = 1'b1;
                end
            end
            wr_en[0] = 1'b1;
        end
    end

    // Occupancy follows whatever each enabled register clocks in
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
        end else begin
            for (int s = 1; s < NUM_STAGES; s++) begin
                if (wr_en[s]) begin
                    valid_r[s] <= !gen_bubble[s] && ((s == 1) ? 1'b1 : valid[s-1]);
                end
            end
        end
    end

    // Drain/halt sequencing; halt is declared only once registered occupancy is empty
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (drain_req)        state <= DRAIN;
                DRAIN:   if (valid_r == '0)    state <= HALTED;
                HALTED:  if (resume_req)       state <= RUN;
                default:                       state <= RUN;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_STAGES; g++) begin : g_cnt
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (valid[g] && stall[g]),
                .clr   (cnt_clear),
                .count (stall_cnt[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pipe_traffic_ctrl.sv
// tb/tb_pipe_traffic_ctrl.sv - directed self-checking bench for pipe_traffic_ctrl
module tb_pipe_traffic_ctrl;

    localparam int N  = 5;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      stall;
    logic              fetch_valid;
    logic [N-1:0]      flush_vec;
    logic              drain_req;
    logic              resume_req;
    logic              cnt_clear;
    logic [N-1:0]      wr_en;
    logic [N-1:0]      gen_bubble;
    logic [N-1:0]      valid;
    logic              drained;
    logic [N*CW-1:0]   stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_traffic_ctrl #(
        .NUM_STAGES(N),
        .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .fetch_valid (fetch_valid),
        .flush_vec   (flush_vec),
        .drain_req   (drain_req),
        .resume_req  (resume_req),
        .cnt_clear   (cnt_clear),
        .wr_en       (wr_en),
        .gen_bubble  (gen_bubble),
        .valid       (valid),
        .drained     (drained),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] cnt(input int s);
        return 32'(stall_cnt[s*CW +: CW]);
    endfunction

    initial begin
        reset = 1'b1; stall = '0; fetch_valid = 1'b0; flush_vec = '0;
        drain_req = 1'b0; resume_req = 1'b0; cnt_clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_wr_en",   32'(wr_en),      32'h1f);
        check("rst_valid",   32'(valid),      32'h00);
        check("rst_bubble",  32'(gen_bubble), 32'h02);
        check("rst_drained", 32'(drained),    32'h0);
        check("rst_cnt",     32'(stall_cnt),  32'h0);

        // 1: fill, one stage per cycle
        fetch_valid = 1'b1;
        #1;
        check("fill_v0",  32'(valid), 32'h01);
        check("fill_we0", 32'(wr_en), 32'h1f);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("fill_valid", 32'(valid), (i >= 4) ? 32'h1f : ((32'h1 << (i + 1)) - 1));
            check("fill_we",    32'(wr_en), 32'h1f);
        end

        // 2: stall in MEM for 3 cycles
        stall = 5'b01000;
        #1;
        check("st3_we",  32'(wr_en),      32'h10);
        check("st3_gb",  32'(gen_bubble), 32'h10);
        tick();
        check("st3_valid", 32'(valid), 32'h0f);
        tick(); tick();
        check("st3_cnt", cnt(3), 32'd3);
        stall = '0;
        tick();
        check("st3_refill", 32'(valid), 32'h1f);
        check("st3_cnt_hold", cnt(3), 32'd3);

        // 3: flush at EX while EX stalls
        flush_vec = 5'b00100; stall = 5'b00100;
        #1;
        check("fl2_we", 32'(wr_en),      32'h1b);
        check("fl2_gb", 32'(gen_bubble), 32'h0e);
        tick();
        flush_vec = '0; stall = '0;
        #1;
        check("fl2_valid", 32'(valid), 32'h15);
        check("fl2_cnt2",  cnt(2),     32'd1);
        tick(); tick(); tick(); tick();
        check("fl2_refill", 32'(valid), 32'h1f);

        // 4: multiple flush points, oldest (WB) wins
        flush_vec = 5'b11100;
        #1;
        check("fl4_we", 32'(wr_en),      32'h1f);
        check("fl4_gb", 32'(gen_bubble), 32'h1e);
        tick();
        flush_vec = '0;
        #1;
        check("fl4_valid", 32'(valid), 32'h01);
        tick(); tick(); tick(); tick();
        check("fl4_refill", 32'(valid), 32'h1f);

        // 5: drain a full pipe, halt, flush in halt, resume
        drain_req = 1'b1;
        #1;
        check("dr_req_we", 32'(wr_en), 32'h1f);
        tick();
        drain_req = 1'b0;
        #1;
        check("dr_we",      32'(wr_en),   32'h1e);
        check("dr_drained", 32'(drained), 32'h0);
        tick(); check("dr_v1", 32'(valid), 32'h1d);
        tick(); check("dr_v2", 32'(valid), 32'h19);
        tick(); check("dr_v3", 32'(valid), 32'h11);
        tick(); check("dr_v4", 32'(valid), 32'h01);
        check("dr_not_yet", 32'(drained), 32'h0);
        tick();
        check("dr_halted", 32'(drained), 32'h1);
        check("halt_we",   32'(wr_en),   32'h1e);
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        check("halt_ign_drain", 32'(drained), 32'h1);
        flush_vec = 5'b00100;
        #1;
        check("halt_flush_we0", 32'(wr_en[0]), 32'h1);
        flush_vec = '0;
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        #1;
        check("resume_we",      32'(wr_en),   32'h1f);
        check("resume_drained", 32'(drained), 32'h0);
        tick(); tick(); tick(); tick();
        check("resume_refill", 32'(valid), 32'h1f);

        // 6: saturate ID counter, then clear while still stalling
        stall = 5'b00010;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt1", cnt(1), 32'd15);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("clr_cnt1", cnt(1), 32'd0);
        check("clr_cnt3", cnt(3), 32'd0);
        stall = '0;
        tick();

        // Reset while draining
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_dr_valid",   32'(valid),   32'h01);
        check("rst_dr_drained", 32'(drained), 32'h0);
        check("rst_dr_we",      32'(wr_en),   32'h1f);
        tick();
        check("rst_dr_run", 32'(valid), 32'h03);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
